conf_reg_bank_db: RTL and testbench

- Runtime, double-buffered configuration register bank for the MAC engine.
- Layer parameters (mode, dims, addresses, strides, sparsity flags) move from compile-time constants to host-programmable registers.
- The host writes the shadow context over the 32-bit external port while the engine runs on the active context.
- Commit handshake swaps contexts only at an engine-idle boundary. Sits between the peripheral write port and the control unit.

---
 rtl/conf_reg_bank_db.sv | 144 ++++++++++++++
 tb/tb_conf_reg_bank_db.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/conf_reg_bank_db.sv
// Double-buffered configuration register bank: the host programs the shadow context while
// the engine runs on the active one; a commit swaps them at an engine-idle boundary.
module conf_reg_bank_db #(
  parameter int N_REGS     = 32,
  parameter int REG_WIDTH  = 32,
  parameter int ADDR_W     = $clog2(N_REGS),
  parameter int MODE_REG   = 0,
  parameter int RESET_MODE = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [ADDR_W-1:0]           wr_addr,
  input  logic [REG_WIDTH-1:0]        wr_data,
  input  logic [REG_WIDTH/8-1:0]      wr_be,
  output logic                        wr_err,
  input  logic                        rd_en,
  input  logic [ADDR_W-1:0]           rd_addr,
  input  logic                        rd_ctx,
  output logic [REG_WIDTH-1:0]        rd_data,
  output logic                        rd_valid,
  input  logic                        commit_req,
  input  logic                        engine_idle,
  output logic                        commit_pending,
  output logic                        commit_ack,
  output logic                        active_sel,
  output logic [15:0]                 layer_cnt,
  output logic [N_REGS*REG_WIDTH-1:0] conf_o,
  output logic [1:0]                  mode_o
);

  localparam int IDX_W = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  localparam int BYTES = REG_WIDTH / 8;
  localparam logic [REG_WIDTH-1:0] MODE_WORD = REG_WIDTH'(RESET_MODE % 4);

  typedef enum logic {IDLE, PEND} state_t;

  state_t state_reg, state_next;
  logic   swap;

  // Two physical contexts held in flops so a full copy fits in one cycle.
  logic [REG_WIDTH-1:0]        ctx_reg [2][N_REGS];
  logic [N_REGS*REG_WIDTH-1:0] shadow_next;

  logic                 active_sel_reg;
  logic                 shadow_sel;
  logic                 commit_ack_reg;
  logic                 wr_err_reg;
  logic                 rd_valid_reg;
  logic [REG_WIDTH-1:0] rd_data_reg;
  logic [15:0]          layer_cnt_reg;

  logic             wr_addr_ok, rd_addr_ok, wr_ok, rd_sel;
  logic [IDX_W-1:0] wr_idx, rd_idx;

  assign wr_addr_ok = (32'(wr_addr) < N_REGS);
  assign rd_addr_ok = (32'(rd_addr) < N_REGS);
  assign wr_idx     = wr_addr[IDX_W-1:0];
  assign rd_idx     = rd_addr[IDX_W-1:0];
  assign wr_ok      = wr_en && wr_addr_ok && (state_reg == IDLE);
  assign shadow_sel = ~active_sel_reg;
  assign rd_sel     = rd_ctx ? shadow_sel : active_sel_reg;

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    swap       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (commit_req) begin
          if (engine_idle) swap = 1'b1;
          else             state_next = PEND;
        end
      end
      PEND: begin
        if (engine_idle) begin
          swap       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Shadow image after this cycle's write; a coincident swap copies this, so the write lands in both.
  generate
    for (genvar gi = 0; gi < N_REGS; gi++) begin : g_reg
      for (genvar gb = 0; gb < BYTES; gb++) begin : g_byte
        assign shadow_next[gi*REG_WIDTH + gb*8 +: 8] =
          (wr_ok && (wr_idx == IDX_W'(gi)) && wr_be[gb]) ? wr_data[gb*8 +: 8]
                                                          : ctx_reg[shadow_sel][gi][gb*8 +: 8];
      end
      assign conf_o[gi*REG_WIDTH +: REG_WIDTH] = ctx_reg[active_sel_reg][gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_REGS; i++) begin
        ctx_reg[0][i] <= (i == MODE_REG) ? MODE_WORD : '0;
        ctx_reg[1][i] <= (i == MODE_REG) ? MODE_WORD : '0;
      end
    end else begin
      for (int i = 0; i < N_REGS; i++) begin
        ctx_reg[shadow_sel][i] <= shadow_next[i*REG_WIDTH +: REG_WIDTH];
        if (swap) ctx_reg[active_sel_reg][i] <= shadow_next[i*REG_WIDTH +: REG_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_sel_reg <= 1'b0;
      commit_ack_reg <= 1'b0;
      layer_cnt_reg  <= '0;
      wr_err_reg     <= 1'b0;
      rd_valid_reg   <= 1'b0;
      rd_data_reg    <= '0;
    end else begin
      commit_ack_reg <= swap;
      wr_err_reg     <= wr_en && !wr_ok;
      rd_valid_reg   <= rd_en;
      if (swap) begin
        active_sel_reg <= ~active_sel_reg;
        layer_cnt_reg  <= layer_cnt_reg + 16'd1;
      end
      if (rd_en) rd_data_reg <= rd_addr_ok ? ctx_reg[rd_sel][rd_idx] : '0;
    end
  end

  assign commit_pending = (state_reg == PEND);
  assign commit_ack     = commit_ack_reg;
  assign active_sel     = active_sel_reg;
  assign layer_cnt      = layer_cnt_reg;
  assign wr_err         = wr_err_reg;
  assign rd_valid       = rd_valid_reg;
  assign rd_data        = rd_data_reg;
  assign mode_o         = ctx_reg[active_sel_reg][MODE_REG][1:0];

endmodule

// File: tb/tb_conf_reg_bank_db.sv
// Bench for conf_reg_bank_db: directed steps plus random traffic against a logical
// active/shadow context model.
module tb_conf_reg_bank_db;

  localparam int NR = 32;
  localparam int RW = 32;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [RW-1:0] wr_data;
  logic [3:0]    wr_be;
  logic          wr_err;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          rd_ctx;
  logic [RW-1:0] rd_data;
  logic          rd_valid;
  logic          commit_req;
  logic          engine_idle;
  logic          commit_pending;
  logic          commit_ack;
  logic          active_sel;
  logic [15:0]   layer_cnt;
  logic [NR*RW-1:0] conf_o;
  logic [1:0]    mode_o;

  conf_reg_bank_db #(
    .N_REGS(NR), .REG_WIDTH(RW), .ADDR_W(AW), .MODE_REG(0), .RESET_MODE(1)
  ) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be), .wr_err(wr_err),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_ctx(rd_ctx), .rd_data(rd_data), .rd_valid(rd_valid),
    .commit_req(commit_req), .engine_idle(engine_idle), .commit_pending(commit_pending),
    .commit_ack(commit_ack), .active_sel(active_sel), .layer_cnt(layer_cnt),
    .conf_o(conf_o), .mode_o(mode_o)
  );

  always #5 clk = ~clk;

  // Reference model in logical terms: what the engine sees vs. what the host is editing.
  logic [RW-1:0] act_m [NR];
  logic [RW-1:0] shd_m [NR];
  logic          sel_m, pend_m;
  logic [15:0]   cnt_m;
  logic          exp_ack, exp_err, exp_rv;
  logic [RW-1:0] exp_rd;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string tag, input logic [NR*RW-1:0] obs, input logic [NR*RW-1:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [NR*RW-1:0] conf_exp();
    logic [NR*RW-1:0] v;
    for (int i = 0; i < NR; i++) v[i*RW +: RW] = act_m[i];
    return v;
  endfunction

  task automatic clear_inputs();
    wr_en = 0; wr_addr = '0; wr_data = '0; wr_be = '0;
    rd_en = 0; rd_addr = '0; rd_ctx = 0;
    commit_req = 0; engine_idle = 0;
  endtask

  // Advance the model by one edge from the current inputs, clock the DUT, compare everything.
  task automatic step();
    logic ok, swp;
    int a;
    if (reset) begin
      for (int i = 0; i < NR; i++) begin
        act_m[i] = (i == 0) ? 32'd1 : 32'd0;
        shd_m[i] = act_m[i];
      end
      sel_m = 0; pend_m = 0; cnt_m = 0;
      exp_ack = 0; exp_err = 0; exp_rv = 0; exp_rd = '0;
    end else begin
      exp_rv = rd_en;
      if (rd_en) begin
        a = int'(rd_addr);
        if (a >= NR) exp_rd = '0;
        else         exp_rd = rd_ctx ? shd_m[a] : act_m[a];
      end
      a = int'(wr_addr);
      ok = wr_en && (a < NR) && !pend_m;
      exp_err = wr_en && !ok;
      if (ok)
        for (int k = 0; k < 4; k++)
          if (wr_be[k]) shd_m[a][k*8 +: 8] = wr_data[k*8 +: 8];
      swp = engine_idle && (pend_m || commit_req);
      exp_ack = swp;
      if (swp) begin
        for (int i = 0; i < NR; i++) act_m[i] = shd_m[i];
        sel_m = ~sel_m; cnt_m = cnt_m + 16'd1; pend_m = 0;
      end else if (commit_req) begin
        pend_m = 1;
      end
    end
    @(posedge clk); #1;
    chk("rd_valid", {1023'd0, rd_valid}, {1023'd0, exp_rv});
    chk("rd_data", {992'd0, rd_data}, {992'd0, exp_rd});
    chk("wr_err", {1023'd0, wr_err}, {1023'd0, exp_err});
    chk("commit_ack", {1023'd0, commit_ack}, {1023'd0, exp_ack});
    chk("commit_pending", {1023'd0, commit_pending}, {1023'd0, pend_m});
    chk("active_sel", {1023'd0, active_sel}, {1023'd0, sel_m});
    chk("layer_cnt", {1008'd0, layer_cnt}, {1008'd0, cnt_m});
    chk("mode_o", {1022'd0, mode_o}, {1022'd0, act_m[0][1:0]});
    chk("conf_o", conf_o, conf_exp());
  endtask

  task automatic rd(input int addr, input logic ctx);
    clear_inputs(); rd_en = 1; rd_addr = AW'(addr); rd_ctx = ctx; step();
  endtask

  initial begin
    clear_inputs();
    reset = 1; step(); step();
    reset = 0;
    chk("rst_layer_cnt", {1008'd0, layer_cnt}, '0);

    // Reset mode visible through readback
    rd(0, 0);
    chk("tp_rd_reg0", {992'd0, rd_data}, {992'd0, 32'h0000_0001});
    chk("tp_mode", {1022'd0, mode_o}, {1022'd0, 2'd1});

    // Byte-enabled shadow write
    clear_inputs(); wr_en = 1; wr_addr = 6'd5; wr_data = 32'hDEADBEEF; wr_be = 4'b0101; step();
    rd(5, 1);
    chk("tp_shadow_r5", {992'd0, rd_data}, {992'd0, 32'h00AD00EF});
    rd(5, 0);
    chk("tp_active_r5", {992'd0, rd_data}, '0);
    chk("tp_conf_r5_pre", {992'd0, conf_o[5*RW +: RW]}, '0);

    // Immediate commit
    clear_inputs(); commit_req = 1; engine_idle = 1; step();
    chk("tp_ack", {1023'd0, commit_ack}, {1023'd0, 1'b1});
    chk("tp_sel", {1023'd0, active_sel}, {1023'd0, 1'b1});
    chk("tp_conf_r5", {992'd0, conf_o[5*RW +: RW]}, {992'd0, 32'h00AD00EF});
    rd(5, 1);
    chk("tp_copy_r5", {992'd0, rd_data}, {992'd0, 32'h00AD00EF});

    // Deferred commit, write rejected while pending
    clear_inputs(); commit_req = 1; step();
    clear_inputs();
    for (int i = 0; i < 10; i++) step();
    chk("tp_pending", {1023'd0, commit_pending}, {1023'd0, 1'b1});
    wr_en = 1; wr_addr = 6'd2; wr_data = 32'h12345678; wr_be = 4'hF; step();
    chk("tp_wr_err", {1023'd0, wr_err}, {1023'd0, 1'b1});
    clear_inputs(); engine_idle = 1; step();
    chk("tp_pend_ack", {1023'd0, commit_ack}, {1023'd0, 1'b1});
    rd(2, 0);
    chk("tp_r2_unchanged", {992'd0, rd_data}, '0);

    // Out-of-range write and read
    clear_inputs(); wr_en = 1; wr_addr = 6'd32; wr_data = 32'hFFFFFFFF; wr_be = 4'hF; step();
    chk("tp_oor_err", {1023'd0, wr_err}, {1023'd0, 1'b1});
    rd(32, 1);
    chk("tp_oor_rd", {992'd0, rd_data}, '0);

    // Write coinciding with an immediate swap
    clear_inputs(); wr_en = 1; wr_addr = 6'd7; wr_data = 32'hCAFEF00D; wr_be = 4'hF;
    commit_req = 1; engine_idle = 1; step();
    chk("tp_wr_swap", {992'd0, conf_o[7*RW +: RW]}, {992'd0, 32'hCAFEF00D});

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      wr_en = ($urandom_range(0, 1) == 1);
      wr_addr = AW'($urandom_range(0, 40));
      wr_data = $urandom();
      wr_be = 4'($urandom_range(0, 15));
      rd_en = ($urandom_range(0, 1) == 1);
      rd_addr = AW'($urandom_range(0, 35));
      rd_ctx = ($urandom_range(0, 1) == 1);
      commit_req = ($urandom_range(0, 4) == 0);
      engine_idle = ($urandom_range(0, 1) == 1);
      step();
    end

    // Reset aborts a pending commit
    clear_inputs(); commit_req = 1; step();
    clear_inputs(); step();
    reset = 1; engine_idle = 1; step();
    reset = 0; clear_inputs(); step();
    chk("tp_rst_pend", {1023'd0, commit_pending}, '0);
    chk("tp_rst_ack", {1023'd0, commit_ack}, '0);
    rd(5, 1);
    chk("tp_rst_shadow", {992'd0, rd_data}, '0);

    // Counter wrap over 2^16 swaps
    clear_inputs(); commit_req = 1; engine_idle = 1;
    for (int n = 0; n < 65536; n++) step();
    clear_inputs(); step();
    chk("tp_cnt_wrap", {1008'd0, layer_cnt}, '0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
